run_control: RTL and testbench

RUN_CONTROL -- requirements
Module: run_control

---
 rtl/run_control_pkg.sv | 16 +
 rtl/run_control_debounce.sv | 43 ++++
 rtl/run_control.sv | 136 +++++++++++++
 tb/tb_run_control.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_control_pkg.sv
// Shared state encoding and counter widths for the processor run/step controller.
package run_control_pkg;

   typedef enum logic [2:0] {
      ST_HOLD   = 3'd0,
      ST_ARM    = 3'd1,
      ST_RUN    = 3'd2,
      ST_PAUSE  = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

   localparam int COUNT_W    = 16;
   localparam int DB_CNT_W   = 16;
   localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/run_control_debounce.sv
// Two-flop synchronizer followed by a stability debouncer for one raw switch or button.
module debounce
   import run_control_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_raw,
   output logic o_level
);

   localparam logic [DB_CNT_W-1:0] LP_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                r_sync1;
   logic                r_sync2;
   logic                r_level;
   logic [DB_CNT_W-1:0] r_diffCnt;

   // r_diffCnt counts consecutive cycles the synchronized input disagrees with r_level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_diffCnt <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_level) begin
            r_diffCnt <= '0;
         end else if (r_diffCnt == LP_LAST) begin
            r_level   <= r_sync2;
            r_diffCnt <= '0;
         end else begin
            r_diffCnt <= r_diffCnt + DB_CNT_W'(1);
         end
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/run_control.sv
// Processor run controller: debounced start/mode/step switches drive a reset/run/single-step FSM.
module run_control
   import run_control_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start_sw,
   input  logic                mode_sw,
   input  logic                step_btn,
   input  logic                halt_req,
   output logic                cpu_reset,
   output logic                cpu_en,
   output logic [2:0]          state,
   output logic [COUNT_W-1:0]  instr_count
);

   logic                  w_start;
   logic                  w_mode;
   logic                  w_step;
   logic                  w_stepPulse;
   logic                  r_stepPrev;
   state_t                r_state;
   logic [HOLD_CNT_W-1:0] r_holdCnt;
   logic                  r_cpuReset;
   logic                  r_cpuEn;
   logic [COUNT_W-1:0]    r_instrCount;

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_startDb (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (start_sw),
      .o_level (w_start)
   );

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_modeDb (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (mode_sw),
      .o_level (w_mode)
   );

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stepDb (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (step_btn),
      .o_level (w_step)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stepPrev <= 1'b0;
      end else begin
         r_stepPrev <= w_step;
      end
   end

   assign w_stepPulse = w_step & ~r_stepPrev;

   // Outputs are registered alongside the state so they describe the cycle being entered
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_HOLD;
         r_holdCnt  <= '0;
         r_cpuReset <= 1'b1;
         r_cpuEn    <= 1'b0;
      end else if (!w_start) begin
         r_state    <= ST_HOLD;
         r_cpuReset <= 1'b1;
         r_cpuEn    <= 1'b0;
      end else begin
         r_cpuEn <= 1'b0;
         case (r_state)
            ST_HOLD: begin
               r_state    <= ST_ARM;
               r_holdCnt  <= HOLD_CNT_W'(HOLD_CYCLES);
               r_cpuReset <= 1'b1;
            end
            ST_ARM: begin
               if (r_holdCnt == HOLD_CNT_W'(1)) begin
                  r_state    <= w_mode ? ST_PAUSE : ST_RUN;
                  r_cpuReset <= 1'b0;
                  r_cpuEn    <= ~w_mode;
               end else begin
                  r_holdCnt <= r_holdCnt - HOLD_CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (halt_req) begin
                  r_state <= ST_HALTED;
               end else if (w_mode) begin
                  r_state <= ST_PAUSE;
               end else begin
                  r_cpuEn <= 1'b1;
               end
            end
            ST_PAUSE: begin
               // A halt only counts when it comes back from the single stepped instruction
               if (r_cpuEn && halt_req) begin
                  r_state <= ST_HALTED;
               end else if (!w_mode) begin
                  r_state <= ST_RUN;
                  r_cpuEn <= 1'b1;
               end else begin
                  r_cpuEn <= w_stepPulse;
               end
            end
            ST_HALTED: begin
               r_state <= ST_HALTED;
            end
            default: begin
               r_state    <= ST_HOLD;
               r_cpuReset <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_instrCount <= '0;
      end else if (r_cpuReset) begin
         r_instrCount <= '0;
      end else if (r_cpuEn) begin
         r_instrCount <= r_instrCount + COUNT_W'(1);
      end
   end

   assign cpu_reset   = r_cpuReset;
   assign cpu_en      = r_cpuEn;
   assign state       = r_state;
   assign instr_count = r_instrCount;

endmodule

// File: tb/tb_run_control.sv
// Scoreboarded bench for run_control: directed scenarios plus random switch activity vs a rule-level model.
module tb_run_control;

   localparam int DC = 4;
   localparam int HC = 3;
   localparam bit [31:0] DB_MASK = (32'd1 << DC) - 32'd1;

   typedef struct packed {
      logic [2:0]  st;
      logic        rst;
      logic        en;
      logic [15:0] cnt;
   } obs_t;

   localparam obs_t RESET_OBS = {3'd0, 1'b1, 1'b0, 16'd0};

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_sw;
   logic        mode_sw;
   logic        step_btn;
   logic        halt_req;
   logic        cpu_reset;
   logic        cpu_en;
   logic [2:0]  state;
   logic [15:0] instr_count;

   obs_t expQ[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model state: spec-level phase names as integers (0 HOLD .. 4 HALTED)
   int          mState;
   int          mArmLeft;
   bit          mStepped;
   bit          mStepPrev;
   logic [15:0] mCount;
   bit          mDb[3];
   bit [31:0]   mRaw[3];
   bit [31:0]   mSeen[3];
   bit          mIn[3];
   bit          mPulse;
   obs_t        mNow;
   obs_t        monExp;
   obs_t        monAct;

   run_control #(
      .DEBOUNCE_CYCLES (DC),
      .HOLD_CYCLES     (HC)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_sw    (start_sw),
      .mode_sw     (mode_sw),
      .step_btn    (step_btn),
      .halt_req    (halt_req),
      .cpu_reset   (cpu_reset),
      .cpu_en      (cpu_en),
      .state       (state),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   function automatic obs_t modelObs();
      obs_t o;
      o.st  = 3'(mState);
      o.rst = (mState == 0) || (mState == 1);
      o.en  = (mState == 2) || ((mState == 3) && mStepped);
      o.cnt = mCount;
      return o;
   endfunction

   // Model: a debounced value flips once its last DC synchronized samples all disagree with it
   always @(posedge clk) begin
      mIn[0] = start_sw;
      mIn[1] = mode_sw;
      mIn[2] = step_btn;
      if (!reset_n) begin
         mState    = 0;
         mArmLeft  = 0;
         mStepped  = 0;
         mStepPrev = 0;
         mCount    = 16'd0;
         for (int i = 0; i < 3; i++) begin
            mDb[i]   = 0;
            mRaw[i]  = '0;
            mSeen[i] = '0;
         end
      end else begin
         mNow   = modelObs();
         mPulse = mDb[2] && !mStepPrev;
         if (mNow.rst) mCount = 16'd0;
         else if (mNow.en) mCount = mCount + 16'd1;
         if (!mDb[0]) begin
            mState   = 0;
            mStepped = 0;
         end else begin
            case (mState)
               0: begin
                  mState   = 1;
                  mArmLeft = HC;
               end
               1: begin
                  if (mArmLeft == 1) begin
                     mState   = mDb[1] ? 3 : 2;
                     mStepped = 0;
                  end else begin
                     mArmLeft = mArmLeft - 1;
                  end
               end
               2: begin
                  if (halt_req) mState = 4;
                  else if (mDb[1]) begin
                     mState   = 3;
                     mStepped = 0;
                  end
               end
               3: begin
                  if (mStepped && halt_req) mState = 4;
                  else if (!mDb[1]) begin
                     mState   = 2;
                     mStepped = 0;
                  end else begin
                     mStepped = mPulse;
                  end
               end
               default: ;
            endcase
         end
         mStepPrev = mDb[2];
         for (int i = 0; i < 3; i++) begin
            mSeen[i] = {mSeen[i][30:0], mRaw[i][1]};
            if (mDb[i] ? ((mSeen[i] & DB_MASK) == 32'd0) : ((mSeen[i] & DB_MASK) == DB_MASK))
               mDb[i] = !mDb[i];
            mRaw[i] = {mRaw[i][30:0], mIn[i]};
         end
      end
      expQ.push_back(modelObs());
   end

   // Monitor: every cycle the DUT presents a full output set, compared against the queued expectation
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monExp = expQ.pop_front();
         if (!reset_n) monExp = RESET_OBS;
         monAct = {state, cpu_reset, cpu_en, instr_count};
         vectors++;
         if (monAct !== monExp) begin
            miscompares++;
            $display("[TB] FAIL cycle-compare @%0t: got state=%0d cpu_reset=%0b cpu_en=%0b instr_count=%0d, expected state=%0d cpu_reset=%0b cpu_en=%0b instr_count=%0d",
                     $time, monAct.st, monAct.rst, monAct.en, monAct.cnt,
                     monExp.st, monExp.rst, monExp.en, monExp.cnt);
         end
      end
   end

   task automatic applyStimulus(input bit st, input bit md, input bit sb, input bit hr, input int cycles);
      start_sw = st;
      mode_sw  = md;
      step_btn = sb;
      halt_req = hr;
      repeat (cycles) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   initial begin
      int budget;
      int len;
      bit st;
      bit md;
      bit sb;

      reset_n  = 1'b0;
      start_sw = 1'b1;
      mode_sw  = 1'b0;
      step_btn = 1'b0;
      halt_req = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #2;
      end
      checkOutput("reset state", state, 0);
      checkOutput("reset cpu_reset", cpu_reset, 1);
      checkOutput("reset cpu_en", cpu_en, 0);
      checkOutput("reset instr_count", instr_count, 0);

      $display("[TB] power-up with start held");
      reset_n = 1'b1;
      applyStimulus(1, 0, 0, 0, 6);
      checkOutput("still hold before debounce", state, 0);
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("arm entered", state, 1);
      applyStimulus(1, 0, 0, 0, 2);
      checkOutput("arm third cycle state", state, 1);
      checkOutput("arm third cycle cpu_reset", cpu_reset, 1);
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("run entry state", state, 2);
      checkOutput("run entry cpu_en", cpu_en, 1);
      checkOutput("run entry cpu_reset", cpu_reset, 0);

      $display("[TB] halt at instr_count 10");
      budget = 0;
      while (instr_count != 16'd10 && budget < 50) begin
         applyStimulus(1, 0, 0, 0, 1);
         budget++;
      end
      checkOutput("reach instr_count 10", instr_count, 10);
      applyStimulus(1, 0, 0, 1, 1);
      checkOutput("halted state", state, 4);
      checkOutput("halted cpu_en", cpu_en, 0);
      checkOutput("halted instr_count", instr_count, 11);
      applyStimulus(1, 1, 1, 0, 12);
      checkOutput("halted ignores step/mode", state, 4);
      checkOutput("halted count frozen", instr_count, 11);
      applyStimulus(0, 0, 0, 0, 12);
      checkOutput("start off from halted", state, 0);

      $display("[TB] start glitch");
      applyStimulus(1, 0, 0, 0, 3);
      applyStimulus(0, 0, 0, 0, 15);
      checkOutput("glitch state", state, 0);
      checkOutput("glitch cpu_reset", cpu_reset, 1);

      $display("[TB] single step mode");
      applyStimulus(1, 1, 0, 0, 1);
      budget = 0;
      while (state != 3'd3 && budget < 40) begin
         applyStimulus(1, 1, 0, 0, 1);
         budget++;
      end
      checkOutput("pause entered", state, 3);
      applyStimulus(1, 1, 0, 0, 5);
      for (int p = 0; p < 3; p++) begin
         applyStimulus(1, 1, 1, 0, 10);
         applyStimulus(1, 1, 0, 0, 10);
      end
      checkOutput("three steps count", instr_count, 3);
      checkOutput("three steps state", state, 3);

      $display("[TB] free run then start dropped");
      applyStimulus(1, 0, 0, 0, 20);
      checkOutput("back to run", state, 2);
      applyStimulus(0, 0, 0, 0, 12);
      checkOutput("drop start state", state, 0);
      checkOutput("drop start cpu_reset", cpu_reset, 1);
      checkOutput("drop start instr_count", instr_count, 0);

      $display("[TB] instr_count wrap");
      budget = 0;
      applyStimulus(1, 0, 0, 0, 1);
      while (instr_count != 16'hFFFF && budget < 70000) begin
         applyStimulus(1, 0, 0, 0, 1);
         budget++;
      end
      checkOutput("reach 0xFFFF", instr_count, 65535);
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("wrap instr_count", instr_count, 0);
      checkOutput("wrap state", state, 2);

      $display("[TB] random activity");
      for (int seg = 0; seg < 400; seg++) begin
         len = $urandom_range(1, 14);
         st  = ($urandom_range(0, 5) != 0);
         md  = $urandom_range(0, 1);
         sb  = $urandom_range(0, 1);
         if ($urandom_range(0, 39) == 0) begin
            reset_n = 1'b0;
            applyStimulus(st, md, sb, 0, 2);
            reset_n = 1'b1;
         end
         for (int c = 0; c < len; c++)
            applyStimulus(st, md, sb, ($urandom_range(0, 39) == 0), 1);
      end
      applyStimulus(0, 0, 0, 0, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
